dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (DM) between two requesters: the CPU load/store port (port 0) and a debug/loader port (port 1).
- The loader uses port 1 to preload programs and data and to read results back.
- Policy: the CPU has fixed priority, bounded by a starvation counter, with a bounded burst lock for the loader.
- Sits between the CPU datapath and DM. It drives the CPU stall and returns read data one cycle after the grant.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- DATA_W, 32, data word width.
- STARVE_MAX, 8, consecutive denied cycles after which a pending port-1 request is forced through.
- BURST_MAX, 4, maximum consecutive port-1 grants under lock before port 0 gets one slot.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  CPU access request.
- p0_we  in  1  CPU write enable.
- p0_addr  in  ADDR_W  CPU address.
- p0_wdata  in  DATA_W  CPU write data.
- p0_gnt  out  1  CPU access issued this cycle.
- p0_stall  out  1  p0_req & ~p0_gnt.
- p0_rvalid  out  1  CPU read data valid.
- p0_rdata  out  DATA_W  CPU read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as p0, for the loader.
- p1_lock  in  1  loader requests back-to-back grants.
- mem_en  out  1  DM access strobe.
- mem_we  out  1  DM write enable.
- mem_addr  out  ADDR_W  DM address.
- mem_wdata  out  DATA_W  DM write data.
- mem_rdata  in  DATA_W  DM read data, valid one cycle after mem_en & ~mem_we.

Behaviour:
- **Grant logic**
  - Grants are combinational from requests and registered state.
  - At most one gnt is high per cycle.
  - The mem_* outputs mux the granted port's fields.
  - mem_en = p0_gnt | p1_gnt.
  - With no request, mem_en = 0 and mem_addr/mem_wdata = 0.
- **State machine**, 2 states:
  - CPU_PRI, the reset state:
    - p0_req=1 → grant p0, unless starve_cnt == STARVE_MAX and p1_req=1, in which case grant p1.
    - p0_req=0 and p1_req=1 → grant p1.
    - Enter BURST when p1 is granted with p1_lock=1.
  - BURST:
    - p1_req & p1_lock & burst_cnt < BURST_MAX → grant p1 and increment burst_cnt.
    - burst_cnt == BURST_MAX with p0_req=1 → grant p0 for one cycle, clear burst_cnt, stay in BURST if p1_lock is still 1.
    - burst_cnt == BURST_MAX with p0_req=0 → keep granting p1 and hold burst_cnt saturated.
    - p1_lock=0 or p1_req=0 → return to CPU_PRI; a pending p0 is granted that same cycle.
- **starve_cnt**
  - Increments when p1_req=1 and p1 is not granted; saturates at STARVE_MAX.
  - Clears on any p1 grant or when p1_req=0.
- **burst_cnt**: counts p1 grants in BURST, including the entry grant. Width is clog2(BURST_MAX+1).
- **Read return**
  - Registered tag {valid, port} is captured on each granted read.
  - Next cycle, pX_rvalid=1 for the tagged port, with pX_rdata = mem_rdata.
  - The other port's rdata is 0.
  - Writes never produce rvalid.
- **Throughput**
  - A new grant may issue in the same cycle as the previous read's rvalid, giving full throughput.
  - Back-to-back reads to different ports return in grant order.
- **Reset**
  - Active (reset=0), asynchronous: state=CPU_PRI, counters=0, tag invalid.
  - All outputs 0, including gnt and mem_en, regardless of the requests.
  - A read granted in the cycle before reset asserts is dropped, with no rvalid.
- **Simultaneous events**: when p0_req and p1_req rise together with starve_cnt=0, p0 wins.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state enum {CPU_PRI, BURST};
  - port id constants PORT_CPU=0 and PORT_DBG=1;
  - the default STARVE_MAX and BURST_MAX.
- One natural sub-module, arb_sat_counter: a saturating counter with inc, clr and max compare. It is instantiated twice, for starve_cnt and burst_cnt.
- The FSM, muxes and return tag stay in the top level.

Test Plan:
- **Reset**: hold reset=0 with p0_req=p1_req=1 → all outputs 0. Release → p0_gnt=1 on the first edge.
- **Read latency**: p0 read addr 0x8, DM holds 13 → p0_rvalid=1 and p0_rdata=13 exactly one cycle later; p1_rvalid stays 0.
- **Starvation**: p0_req held high and p1_req=1 → p1_gnt=1 on the 9th cycle (starve_cnt=8). p0_stall=1 in that cycle only; starve_cnt then reads 0.
- **Burst**: p1_lock=1 with both ports requesting → grant pattern p1 ×4, p0 ×1, p1 ×4. Dropping p1_lock grants p0 in the same cycle.
- **Loader write then CPU read**: p1 writes 10 words (Fibonacci 0..34) to 0x00–0x24, then the CPU reads each → rdata matches and p0_rvalid asserts once per read.
- **Mid-operation reset**: assert reset in the cycle after a p1 read grant → no p1_rvalid, FSM back to CPU_PRI, counters 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Port ids tag read returns; the state enum is used by the arbiter FSM.
package dmem_arb_pkg;

  typedef enum logic {
    CPU_PRI = 1'b0,
    BURST   = 1'b1
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int STARVE_MAX_DEF = 8;
  localparam int BURST_MAX_DEF  = 4;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear and a reached-maximum flag.
// Clear takes precedence over increment.
module arb_sat_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  logic [W-1:0] r_cnt;

  assign o_at_max = (r_cnt == W'(MAX));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_at_max) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: CPU has fixed
// priority, the loader is protected by a starvation limit and a burst lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_stall,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_stall,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       w_p0_req;
  logic       w_p1_req;
  logic       w_cpu_gnt0;
  logic       w_cpu_gnt1;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_starve_max;
  logic       w_burst_max;
  logic       w_burst_clr;
  logic       r_tag_valid;
  logic       r_tag_port;

  // Requests are masked while reset is held so every output stays 0.
  assign w_p0_req = p0_req & reset;
  assign w_p1_req = p1_req & reset;

  assign w_cpu_gnt1 = w_p1_req & (~w_p0_req | w_starve_max);
  assign w_cpu_gnt0 = w_p0_req & ~w_cpu_gnt1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      CPU_PRI: begin
        w_gnt0 = w_cpu_gnt0;
        w_gnt1 = w_cpu_gnt1;
        if (w_cpu_gnt1 && p1_lock) w_state_nxt = BURST;
      end
      BURST: begin
        if (w_p1_req && p1_lock) begin
          if (w_burst_max && w_p0_req) w_gnt0 = 1'b1;
          else                         w_gnt1 = 1'b1;
        end else begin
          w_gnt0      = w_cpu_gnt0;
          w_gnt1      = w_cpu_gnt1;
          w_state_nxt = CPU_PRI;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= CPU_PRI;
    else        r_state <= w_state_nxt;
  end

  arb_sat_counter #(.MAX(STARVE_MAX)) u_starve_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .i_inc    (w_p1_req & ~w_gnt1),
    .i_clr    (~w_p1_req | w_gnt1),
    .o_at_max (w_starve_max)
  );

  // The burst count restarts after the CPU slot and whenever the lock ends.
  assign w_burst_clr = ((r_state == BURST) && w_gnt0) || (w_state_nxt == CPU_PRI);

  arb_sat_counter #(.MAX(BURST_MAX)) u_burst_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .i_inc    (w_gnt1),
    .i_clr    (w_burst_clr),
    .o_at_max (w_burst_max)
  );

  assign p0_gnt   = w_gnt0;
  assign p1_gnt   = w_gnt1;
  assign p0_stall = w_p0_req & ~w_gnt0;
  assign p1_stall = w_p1_req & ~w_gnt1;
  assign mem_en   = w_gnt0 | w_gnt1;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (w_gnt1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // Return tag: remembers which port owns the read data arriving next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_valid <= 1'b0;
      r_tag_port  <= PORT_CPU;
    end else begin
      r_tag_valid <= mem_en & ~mem_we;
      r_tag_port  <= w_gnt1 ? PORT_DBG : PORT_CPU;
    end
  end

  assign p0_rvalid = r_tag_valid && (r_tag_port == PORT_CPU);
  assign p1_rvalid = r_tag_valid && (r_tag_port == PORT_DBG);
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a behavioural model of the arbitration
// rules and of memory contents predicts every output each cycle.
module tb_dmem_arbiter;

  localparam int SMAX = 8;
  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_stall, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_stall(p1_stall), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return (i == 2) ? 32'd13 : (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Single-port memory with one-cycle read latency.
  logic [31:0] dm [64];
  logic        dm_loaded = 1'b0;
  always @(posedge clk) begin
    if (!dm_loaded) begin
      for (int i = 0; i < 64; i++) dm[i] <= seed_word(i);
      dm_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) dm[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= dm[mem_addr[7:2]];
    end
  end

  // Reference model state.
  logic [31:0] mref [64];
  bit          m_burst;
  int          m_starve, m_bcnt;
  bit          m_rv, m_rv_port;
  logic [31:0] m_rv_data;
  bit          obs_g0, obs_g1, obs_s0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_burst = 0; m_starve = 0; m_bcnt = 0; m_rv = 0; m_rv_port = 0; m_rv_data = '0;
  endtask

  function automatic void model_grant(output bit g0, output bit g1);
    bit cpu0, cpu1;
    cpu1 = p1_req && (!p0_req || m_starve == SMAX);
    cpu0 = p0_req && !cpu1;
    g0 = cpu0; g1 = cpu1;
    if (m_burst && p1_req && p1_lock) begin
      g0 = (m_bcnt == BMAX) && p0_req;
      g1 = !g0;
    end
  endfunction

  // One clock cycle: check predicted outputs mid-cycle, then advance the model.
  task automatic step();
    bit g0, g1, we;
    logic [31:0] a, wd;
    bit nb;
    @(negedge clk);
    model_grant(g0, g1);
    we = g0 ? p0_we : (g1 ? p1_we : 1'b0);
    a  = g0 ? p0_addr : (g1 ? p1_addr : 32'h0);
    wd = g0 ? p0_wdata : (g1 ? p1_wdata : 32'h0);
    obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_s0 = p0_stall;
    check("p0_gnt", p0_gnt, g0);
    check("p1_gnt", p1_gnt, g1);
    check("p0_stall", p0_stall, p0_req && !g0);
    check("p1_stall", p1_stall, p1_req && !g1);
    check("mem_en", mem_en, g0 || g1);
    check("mem_we", mem_we, we);
    check("mem_addr", mem_addr, a);
    check("mem_wdata", mem_wdata, wd);
    check("p0_rvalid", p0_rvalid, m_rv && !m_rv_port);
    check("p1_rvalid", p1_rvalid, m_rv && m_rv_port);
    check("p0_rdata", p0_rdata, (m_rv && !m_rv_port) ? m_rv_data : 32'h0);
    check("p1_rdata", p1_rdata, (m_rv && m_rv_port) ? m_rv_data : 32'h0);
    @(posedge clk);
    m_starve = (p1_req && !g1) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    nb = m_burst ? (p1_req && p1_lock) : (g1 && p1_lock);
    if (!nb)     m_bcnt = 0;
    else if (g1) m_bcnt = (m_bcnt < BMAX) ? m_bcnt + 1 : BMAX;
    else         m_bcnt = 0;
    m_burst = nb;
    m_rv = (g0 || g1) && !we;
    m_rv_port = g1;
    if (m_rv) m_rv_data = mref[a[7:2]];
    if ((g0 || g1) && we) mref[a[7:2]] = wd;
    #1;
  endtask

  task automatic idle(input int n);
    p0_req = 0; p1_req = 0; p1_lock = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_inputs();
    logic [5:0] w0, w1;
    w0 = 6'($urandom_range(0, 63));
    w1 = 6'($urandom_range(0, 63));
    p0_req = ($urandom_range(0, 9) < 7);
    p0_we = 1'($urandom_range(0, 1));
    p0_addr = {24'h0, w0, 2'b00};
    p0_wdata = $urandom();
    p1_req = ($urandom_range(0, 9) < 6);
    p1_we = 1'($urandom_range(0, 1));
    p1_addr = {24'h0, w1, 2'b00};
    p1_wdata = $urandom();
    if ($urandom_range(0, 9) < 2) p1_lock = ~p1_lock;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int first, stalls, bit_stall;
    logic [8:0] pattern;
    logic [31:0] fib [10];

    for (int i = 0; i < 64; i++) mref[i] = seed_word(i);
    model_reset();

    // Reset held with both ports requesting: everything must stay quiet.
    reset = 0;
    p0_req = 1; p0_we = 1; p0_addr = 32'h40; p0_wdata = 32'hDEAD;
    p1_req = 1; p1_we = 0; p1_addr = 32'h44; p1_wdata = 32'hBEEF; p1_lock = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_p1_gnt", p1_gnt, 0);
    check("rst_stall", {p0_stall, p1_stall}, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    @(posedge clk); #1;
    reset = 1; p0_we = 0; p1_lock = 0;
    step();
    check("rst_release_p0_first", obs_g0, 1);
    idle(2);

    // Read latency: word at 0x8 holds 13.
    p0_req = 1; p0_we = 0; p0_addr = 32'h8;
    step();
    p0_req = 0;
    check("lat_p0_rvalid", p0_rvalid, 1);
    check("lat_p0_rdata", p0_rdata, 32'd13);
    check("lat_p1_rvalid", p1_rvalid, 0);
    idle(2);

    // Starvation: CPU hogs the port, loader forced through on cycle 9.
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    p1_req = 1; p1_we = 0; p1_addr = 32'h14; p1_lock = 0;
    first = 0; stalls = 0; bit_stall = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      stalls += int'(obs_s0);
      if (obs_g1) begin
        first = i; bit_stall = int'(obs_s0);
        break;
      end
    end
    check("starve_cycle", first, 9);
    check("starve_stall_that_cycle", bit_stall, 1);
    check("starve_stall_count", stalls, 1);
    check("starve_cnt_cleared", dut.u_starve_cnt.r_cnt, 0);
    idle(2);

    // Burst: entry grant, then p1 x4 / p0 x1 / p1 x4.
    p0_req = 0; p0_we = 0; p0_addr = 32'h20;
    p1_req = 1; p1_we = 1; p1_addr = 32'h30; p1_wdata = 32'h1234_5678; p1_lock = 1;
    step();
    pattern[0] = obs_g1;
    p0_req = 1;
    for (int k = 1; k < 9; k++) begin
      step();
      pattern[k] = obs_g1;
    end
    check("burst_pattern", pattern, 9'h1EF);
    p1_lock = 0;
    step();
    check("burst_exit_p0", obs_g0, 1);
    idle(2);

    // Loader writes Fibonacci words, CPU reads them back.
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i < 10; i++) fib[i] = fib[i-1] + fib[i-2];
    p1_req = 1; p1_we = 1; p1_lock = 0;
    for (int i = 0; i < 10; i++) begin
      p1_addr = 32'(4 * i); p1_wdata = fib[i];
      step();
    end
    p1_req = 0; p0_req = 1; p0_we = 0;
    for (int i = 0; i < 10; i++) begin
      p0_addr = 32'(4 * i);
      step();
      check("fib_rvalid", p0_rvalid, 1);
      check("fib_rdata", p0_rdata, fib[i]);
    end
    idle(1);
    check("fib_no_extra_rvalid", p0_rvalid, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end
    idle(3);

    // Reset right after a locked loader read: the read is dropped.
    p1_req = 1; p1_we = 0; p1_addr = 32'h18; p1_lock = 1;
    step();
    reset = 0; p1_req = 0; p1_lock = 0;
    #1;
    model_reset();
    check("midrst_p1_rvalid", p1_rvalid, 0);
    check("midrst_p1_rdata", p1_rdata, 0);
    check("midrst_state", dut.r_state, 0);
    check("midrst_burst_cnt", dut.u_burst_cnt.r_cnt, 0);
    check("midrst_starve_cnt", dut.u_starve_cnt.r_cnt, 0);
    @(posedge clk); #1;
    reset = 1;
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
